// File: rtl/ifid_hazard_ctrl.sv
// ifid_hazard_ctrl: front-end stall/flush sequencer for the PC and IF/ID buffer, with ID/EX bubbles.
// Optional perf counters are enabled with PIPE_PERF_EN. Revision 1.0.
`default_nettype none

module ifid_hazard_ctrl #(
   parameter int LU_CYC   = 1,
   parameter int IMEM_TMO = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rt,
   input  logic        branch_taken,
   input  logic        imem_ready,
   input  logic        ext_hold,
   output logic        pc_we,
   output logic        ifid_we,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic [1:0]  state,
   output logic        imem_err,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_LU   = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   localparam logic [1:0] c_LU_INIT = 2'(LU_CYC - 1);
   localparam logic [7:0] c_TMO     = 8'(IMEM_TMO);

   state_t     r_state, w_next;
   logic [1:0] r_lu_cnt, w_lu_next;
   logic [7:0] r_wait_cnt, w_wait_next;
   logic       r_err, w_err_next;
   logic       w_hz, w_br;

   assign w_hz = ex_memread && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      w_next      = r_state;
      w_lu_next   = r_lu_cnt;
      w_wait_next = r_wait_cnt;
      w_err_next  = r_err;
      w_br        = 1'b0;
      if (rst) begin
         pc_we       = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         w_br        = 1'b1;
         w_next      = S_RUN;
         w_lu_next   = 2'd0;
         w_wait_next = 8'd0;
      end else if (ext_hold) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
         w_next      = S_HOLD;
      end else if (r_state == S_LU) begin
         // Committed stall: hazard and imem status are ignored until the count runs out.
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
         w_lu_next   = r_lu_cnt - 2'd1;
         if (r_lu_cnt <= 2'd1)
            w_next = S_RUN;
      end else if (w_hz) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
         w_lu_next   = c_LU_INIT;
         if (LU_CYC > 1)
            w_next = S_LU;
         else
            w_next = imem_ready ? S_RUN : S_WAIT;
      end else if (!imem_ready) begin
         pc_we      = 1'b0;
         ifid_flush = 1'b1;
         w_next     = S_WAIT;
         if (r_wait_cnt < c_TMO) begin
            w_wait_next = r_wait_cnt + 8'd1;
            if (r_wait_cnt + 8'd1 == c_TMO)
               w_err_next = 1'b1;
         end
      end else begin
         w_next      = S_RUN;
         w_wait_next = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_RUN;
         r_lu_cnt   <= 2'd0;
         r_wait_cnt <= 8'd0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_lu_cnt   <= w_lu_next;
         r_wait_cnt <= w_wait_next;
         r_err      <= w_err_next;
      end
   end

   assign state    = r_state;
   assign imem_err = r_err;

`ifdef PIPE_PERF_EN
   logic [31:0] r_stall_cycles, r_flush_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= 32'd0;
         r_flush_count  <= 32'd0;
      end else begin
         if (!pc_we)
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if (w_br)
            r_flush_count <= r_flush_count + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`else
   assign stall_cycles = 32'd0;
   assign flush_count  = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifid_hazard_ctrl.sv
// tb_ifid_hazard_ctrl: directed scoreboard bench driving an LU_CYC=1 and an LU_CYC=2 instance in parallel.
`default_nettype none

module tb_ifid_hazard_ctrl;

   localparam logic [3:0] c_ADV  = 4'b1100;
   localparam logic [3:0] c_BR   = 4'b1111;
   localparam logic [3:0] c_HOLD = 4'b0001;
   localparam logic [3:0] c_LU   = 4'b0001;
   localparam logic [3:0] c_MISS = 4'b0110;
   localparam logic [3:0] c_RST  = 4'b0111;

   typedef struct packed {
      logic [3:0] a1;
      logic [1:0] s1;
      logic [3:0] a2;
      logic [1:0] s2;
      logic       e;
   } exp_t;

   logic clk = 1'b0;
   logic rst, branch_taken, imem_ready, ext_hold, ex_memread, id_uses_rt;
   logic [4:0] id_rs, id_rt, ex_rt;

   logic        pc1, we1, fl1, bb1, err1, pc2, we2, fl2, bb2, err2;
   logic [1:0]  st1, st2;
   logic [31:0] sc1, fc1, sc2, fc2;

   int total = 0;
   int bad   = 0;
   int m_sc1 = 0, m_fc1 = 0, m_sc2 = 0, m_fc2 = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   ifid_hazard_ctrl #(.LU_CYC(1), .IMEM_TMO(255)) u_dut1 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
      .imem_ready(imem_ready), .ext_hold(ext_hold),
      .pc_we(pc1), .ifid_we(we1), .ifid_flush(fl1), .idex_bubble(bb1),
      .state(st1), .imem_err(err1), .stall_cycles(sc1), .flush_count(fc1));

   ifid_hazard_ctrl #(.LU_CYC(2), .IMEM_TMO(255)) u_dut2 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
      .imem_ready(imem_ready), .ext_hold(ext_hold),
      .pc_we(pc2), .ifid_we(we2), .ifid_flush(fl2), .idex_bubble(bb2),
      .state(st2), .imem_err(err2), .stall_cycles(sc2), .flush_count(fc2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: inputs already driven; expectation queued, then popped once outputs settle.
   task automatic cyc(input logic [3:0] a1, input logic [1:0] s1,
                      input logic [3:0] a2, input logic [1:0] s2, input logic e);
      exp_t x;
      sb.push_back('{a1: a1, s1: s1, a2: a2, s2: s2, e: e});
      #1;
      x = sb.pop_front();
      chk("act1", {28'd0, pc1, we1, fl1, bb1}, {28'd0, x.a1});
      chk("state1", {30'd0, st1}, {30'd0, x.s1});
      chk("err1", {31'd0, err1}, {31'd0, x.e});
      chk("act2", {28'd0, pc2, we2, fl2, bb2}, {28'd0, x.a2});
      chk("state2", {30'd0, st2}, {30'd0, x.s2});
      chk("err2", {31'd0, err2}, {31'd0, x.e});
      if (rst) begin
         m_sc1 = 0; m_fc1 = 0; m_sc2 = 0; m_fc2 = 0;
      end else begin
         if (!x.a1[3]) m_sc1++;
         if (!x.a2[3]) m_sc2++;
         if (x.a1 == c_BR) m_fc1++;
         if (x.a2 == c_BR) m_fc2++;
      end
      @(negedge clk);
   endtask

   task automatic chk_perf();
`ifdef PIPE_PERF_EN
      chk("stall1", sc1, m_sc1);
      chk("flush1", fc1, m_fc1);
      chk("stall2", sc2, m_sc2);
      chk("flush2", fc2, m_fc2);
`else
      chk("stall1", sc1, 32'd0);
      chk("flush1", fc1, 32'd0);
      chk("stall2", sc2, 32'd0);
      chk("flush2", fc2, 32'd0);
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; branch_taken = 1'b0; imem_ready = 1'b1; ext_hold = 1'b0;
      ex_memread = 1'b0; id_uses_rt = 1'b0; id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd0;
      @(negedge clk);

      cyc(c_RST, 2'd0, c_RST, 2'd0, 1'b0);
      cyc(c_RST, 2'd0, c_RST, 2'd0, 1'b0);
      rst = 1'b0;
      cyc(c_ADV, 2'd0, c_ADV, 2'd0, 1'b0);

      // load-use on rs
      ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      cyc(c_LU, 2'd0, c_LU, 2'd0, 1'b0);
      ex_memread = 1'b0;
      cyc(c_ADV, 2'd0, c_LU, 2'd1, 1'b0);
      cyc(c_ADV, 2'd0, c_ADV, 2'd0, 1'b0);

      // $zero destination never stalls
      ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      cyc(c_ADV, 2'd0, c_ADV, 2'd0, 1'b0);

      // rt match only counts when rt is read
      ex_rt = 5'd5; id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1'b1;
      cyc(c_LU, 2'd0, c_LU, 2'd0, 1'b0);
      id_uses_rt = 1'b0;
      cyc(c_ADV, 2'd0, c_LU, 2'd1, 1'b0);
      ex_memread = 1'b0;
      cyc(c_ADV, 2'd0, c_ADV, 2'd0, 1'b0);

      // imem misses then a taken branch
      imem_ready = 1'b0;
      cyc(c_MISS, 2'd0, c_MISS, 2'd0, 1'b0);
      cyc(c_MISS, 2'd2, c_MISS, 2'd2, 1'b0);
      cyc(c_MISS, 2'd2, c_MISS, 2'd2, 1'b0);
      branch_taken = 1'b1;
      cyc(c_BR, 2'd2, c_BR, 2'd2, 1'b0);
      branch_taken = 1'b0; imem_ready = 1'b1;
      cyc(c_ADV, 2'd0, c_ADV, 2'd0, 1'b0);

      // external hold over a hazard, then branch beats hold
      ext_hold = 1'b1; ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      cyc(c_HOLD, 2'd0, c_HOLD, 2'd0, 1'b0);
      cyc(c_HOLD, 2'd3, c_HOLD, 2'd3, 1'b0);
      ext_hold = 1'b0;
      cyc(c_LU, 2'd3, c_LU, 2'd3, 1'b0);
      ex_memread = 1'b0;
      cyc(c_ADV, 2'd0, c_LU, 2'd1, 1'b0);
      ext_hold = 1'b1; branch_taken = 1'b1;
      cyc(c_BR, 2'd0, c_BR, 2'd0, 1'b0);
      branch_taken = 1'b0;
      cyc(c_HOLD, 2'd0, c_HOLD, 2'd0, 1'b0);
      cyc(c_HOLD, 2'd3, c_HOLD, 2'd3, 1'b0);
      branch_taken = 1'b1;
      cyc(c_BR, 2'd3, c_BR, 2'd3, 1'b0);
      branch_taken = 1'b0; ext_hold = 1'b0;
      cyc(c_ADV, 2'd0, c_ADV, 2'd0, 1'b0);
      chk_perf();

      // imem timeout: error appears after the 255th miss and sticks until reset
      for (int k = 1; k <= 300; k++) begin
         imem_ready = 1'b0;
         cyc(c_MISS, (k == 1) ? 2'd0 : 2'd2, c_MISS, (k == 1) ? 2'd0 : 2'd2, (k >= 256));
      end
      imem_ready = 1'b1;
      cyc(c_ADV, 2'd2, c_ADV, 2'd2, 1'b1);
      cyc(c_ADV, 2'd0, c_ADV, 2'd0, 1'b1);
      imem_ready = 1'b0;
      cyc(c_MISS, 2'd0, c_MISS, 2'd0, 1'b1);
      cyc(c_MISS, 2'd2, c_MISS, 2'd2, 1'b1);
      chk_perf();

      // reset in the middle of a wait
      rst = 1'b1;
      cyc(c_RST, 2'd2, c_RST, 2'd2, 1'b1);
      cyc(c_RST, 2'd0, c_RST, 2'd0, 1'b0);
      rst = 1'b0; imem_ready = 1'b1;
      cyc(c_ADV, 2'd0, c_ADV, 2'd0, 1'b0);
      chk_perf();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
